bridge_arbiter: RTL

Shares the single system bridge port (PrAddr/PrBE/PrWD/PrWE/PrRD) between two bus masters: the CPU MEM stage (master 0) and a DMA engine (master 1). The CPU has default priority. A starvation counter guarantees the DMA forward progress, and the DMA may lock the bus for short bursts. It sits between the CPU/DMA and the bridge; the bridge's address decode (DM, Timer1, Timer2) is unchanged.

---
 rtl/bridge_arbiter_pkg.sv | 22 ++
 rtl/bridge_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bridge_arbiter_pkg.sv
// Shared definitions for the CPU/DMA bridge arbiter: owner encoding,
// grant classification and parameter defaults.
package bridge_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  // GNT_DMA_LOCK marks a DMA grant that continues a locked burst.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_DMA_LOCK,
    GNT_DMA
  } grant_t;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned BURST_MAX_DEF    = 8;

endpackage

// File: rtl/bridge_arbiter.sv
// Two-master arbiter in front of the system bridge: CPU has default priority,
// DMA gets starvation relief and short locked bursts.
module bridge_arbiter
  import bridge_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned BURST_MAX    = BURST_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wd,
  input  logic        cpu_we,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [3:0]  dma_be,
  input  logic [31:0] dma_wd,
  input  logic        dma_we,
  output logic        dma_ack,
  output logic [31:0] rdata,
  output logic [31:0] PrAddr,
  output logic [3:0]  PrBE,
  output logic [31:0] PrWD,
  output logic        PrWE,
  input  logic [31:0] PrRD
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);

  owner_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [3:0] burst_q, burst_d;
  logic       lock_q, lock_d;
  grant_t     gnt;

  function automatic grant_t grant_sel(
    input owner_t     st,
    input logic       lk,
    input logic [3:0] burst,
    input logic [3:0] starve,
    input logic       creq,
    input logic       dreq
  );
    if (st == OWN_DMA && lk && dreq && burst < BURST_LIM) return GNT_DMA_LOCK;
    else if (dreq && starve == STARVE_LIM)                 return GNT_DMA;
    else if (creq)                                         return GNT_CPU;
    else if (dreq)                                         return GNT_DMA;
    else                                                   return GNT_NONE;
  endfunction

  assign gnt = grant_sel(state_q, lock_q, burst_q, starve_q, cpu_req, dma_req);

  // Address/data stay muxed during reset; acks (and with them PrWE) are held
  // off so nothing is reported or committed in the reset cycle.
  always_comb begin
    PrAddr  = '0;
    PrBE    = '0;
    PrWD    = '0;
    PrWE    = 1'b0;
    cpu_ack = 1'b0;
    dma_ack = 1'b0;
    case (gnt)
      GNT_CPU: begin
        PrAddr  = cpu_addr;
        PrBE    = cpu_be;
        PrWD    = cpu_wd;
        PrWE    = cpu_we & ~reset;
        cpu_ack = ~reset;
      end
      GNT_DMA, GNT_DMA_LOCK: begin
        PrAddr  = dma_addr;
        PrBE    = dma_be;
        PrWD    = dma_wd;
        PrWE    = dma_we & ~reset;
        dma_ack = ~reset;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign rdata     = PrRD;

  always_comb begin
    state_d  = OWN_IDLE;
    lock_d   = 1'b0;
    burst_d  = '0;
    starve_d = '0;
    case (gnt)
      GNT_CPU: begin
        state_d = OWN_CPU;
        if (dma_req)
          starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
      end
      GNT_DMA_LOCK: begin
        state_d = OWN_DMA;
        lock_d  = dma_lock;
        burst_d = burst_q + 4'd1;
      end
      GNT_DMA: begin
        state_d = OWN_DMA;
        lock_d  = dma_lock;
        burst_d = 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= OWN_IDLE;
      starve_q <= '0;
      burst_q  <= '0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
      lock_q   <= lock_d;
    end
  end

endmodule
